// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared constants for the instruction-fetch sequencer: state codes,
// default reset PC and the sequential PC increment.
package fetch_pkg;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t ST_IDLE   = 2'd0;
   localparam fetch_state_t ST_REQ    = 2'd1;
   localparam fetch_state_t ST_WAIT   = 2'd2;
   localparam fetch_state_t ST_CANCEL = 2'd3;

   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
   localparam int unsigned PC_INC         = 4;

endpackage

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives a split-transaction
// instruction memory port with at most one request in flight, holds one
// fetched instruction for ID, and applies branch/jump redirects, cancelling
// any fetch that is already in flight.
module fetch_seq_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned     PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(FETCH_RESET_PC)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            id_allowin,
   output logic            inst_req,
   output logic [PC_W-1:0] inst_addr,
   input  logic            inst_addr_ok,
   input  logic            inst_data_ok,
   input  logic [PC_W-1:0] inst_rdata,
   output logic            if_valid,
   output logic [PC_W-1:0] if_pc,
   output logic [PC_W-1:0] if_inst
);

   fetch_state_t    state;
   fetch_state_t    state_nxt;
   logic [PC_W-1:0] fetch_pc;
   logic [PC_W-1:0] req_pc;
   logic [PC_W-1:0] redirect_pc_al;
   logic            redirect_act;
   logic            handshake;
   logic            data_take;

   assign inst_addr = fetch_pc;

   // Request gating, handshake/redirect qualification and next-state decode
   always_comb begin
      redirect_pc_al = redirect_pc & ~PC_W'(PC_INC - 1);
      // IDLE only exists for one cycle after reset and ignores redirects
      redirect_act   = redirect_valid && (state != ST_IDLE);
      // Only fetch when the output register is free or being drained, so a
      // returning instruction always finds room without a skid buffer
      inst_req       = (state == ST_REQ) && (!if_valid || id_allowin);
      handshake      = inst_req && inst_addr_ok;
      data_take      = (state == ST_WAIT) && inst_data_ok && !redirect_valid;
      state_nxt      = state;
      case (state)
         ST_IDLE:   state_nxt = ST_REQ;
         ST_REQ: begin
            // An accepted request whose target is being redirected away
            // must still have its data drained, hence CANCEL
            if (handshake)
               state_nxt = redirect_valid ? ST_CANCEL : ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect_valid)
               state_nxt = inst_data_ok ? ST_REQ : ST_CANCEL;
            else if (inst_data_ok)
               state_nxt = ST_REQ;
         end
         ST_CANCEL: begin
            if (inst_data_ok)
               state_nxt = ST_REQ;
         end
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (!resetn)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Fetch PC: redirect target beats the sequential increment
   always_ff @(posedge clk) begin
      if (!resetn)
         fetch_pc <= RESET_PC;
      else if (redirect_act)
         fetch_pc <= redirect_pc_al;
      else if (data_take)
         fetch_pc <= req_pc + PC_W'(PC_INC);
   end

   // Address of the request currently in flight, captured on acceptance
   always_ff @(posedge clk) begin
      if (handshake)
         req_pc <= fetch_pc;
   end

   // IF output register: redirect flushes, new data replaces, consume clears
   always_ff @(posedge clk) begin
      if (!resetn) begin
         if_valid <= 1'b0;
         if_pc    <= '0;
         if_inst  <= '0;
      end else if (redirect_act) begin
         if_valid <= 1'b0;
      end else if (data_take) begin
         if_valid <= 1'b1;
         if_pc    <= req_pc;
         if_inst  <= inst_rdata;
      end else if (id_allowin) begin
         if_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: directed scenarios followed by randomized traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_fetch_seq_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_allowin;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   int n_checks = 0;
   int n_errors = 0;

   fetch_seq_ctrl #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_allowin     (id_allowin),
      .inst_req       (inst_req),
      .inst_addr      (inst_addr),
      .inst_addr_ok   (inst_addr_ok),
      .inst_data_ok   (inst_data_ok),
      .inst_rdata     (inst_rdata),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: fetch pointer, one in-flight transaction (possibly
   // doomed by a redirect) and the instruction held for ID.
   bit          m_started;
   bit          m_out;
   bit          m_killed;
   logic [31:0] m_out_addr;
   logic [31:0] m_pc;
   bit          m_hv;
   logic [31:0] m_hpc;
   logic [31:0] m_hinst;

   function automatic bit m_req(input bit al);
      return m_started && !m_out && (!m_hv || al);
   endfunction

   task automatic model_reset();
      m_started = 0; m_out = 0; m_killed = 0; m_out_addr = 0;
      m_pc = 32'h0; m_hv = 0; m_hpc = 0; m_hinst = 0;
   endtask

   task automatic model_update(input bit rn, input bit rv, input logic [31:0] rpc,
                               input bit al, input bit aok, input bit dok,
                               input logic [31:0] rd);
      bit er;
      bit wrote;
      if (!rn) begin
         model_reset();
      end else if (!m_started) begin
         m_started = 1;
      end else begin
         er    = m_req(al);
         wrote = m_out && !m_killed && dok && !rv;
         if (m_out && dok)     m_out = 0;
         else if (m_out && rv) m_killed = 1;
         if (er && aok) begin
            m_out = 1; m_out_addr = m_pc; m_killed = rv;
         end
         if (rv)            m_hv = 0;
         else if (wrote)    begin m_hv = 1; m_hpc = m_out_addr; m_hinst = rd; end
         else if (al)       m_hv = 0;
         if (rv)            m_pc = rpc & 32'hFFFF_FFFC;
         else if (wrote)    m_pc = m_out_addr + 32'd4;
      end
   endtask

   // Memory responder state
   bit          pend_on = 0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = 0;
   bit          force_en = 0;
   logic [31:0] force_val = 0;
   logic [31:0] hs_log[$];

   // One clock cycle: drive inputs at negedge, compare at negedge+1, advance model
   task automatic step(input bit rn, input bit rv, input logic [31:0] rpc,
                       input bit al, input bit aok, input int dly);
      bit er;
      @(negedge clk);
      resetn = rn; redirect_valid = rv; redirect_pc = rpc;
      id_allowin = al; inst_addr_ok = aok;
      inst_data_ok = 1'b0; inst_rdata = $urandom;
      if (pend_on) begin
         pend_cnt--;
         if (pend_cnt <= 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = force_en ? force_val : (pend_addr ^ 32'hA5A5_0000);
            pend_on      = 0;
         end
      end
      #1;
      er = m_req(al);
      chk("inst_req", inst_req, er);
      if (er) chk("inst_addr", inst_addr, m_pc);
      chk("if_valid", if_valid, m_hv);
      if (m_hv || !m_started) begin
         chk("if_pc", if_pc, m_hpc);
         chk("if_inst", if_inst, m_hinst);
      end
      if (rn && inst_req && aok) begin
         pend_on = 1; pend_cnt = dly; pend_addr = inst_addr;
         hs_log.push_back(inst_addr);
      end
      model_update(rn, rv, rpc, al, aok, inst_data_ok, inst_rdata);
   endtask

   initial begin
      resetn = 0; redirect_valid = 0; redirect_pc = 0; id_allowin = 1;
      inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
      repeat (2) @(negedge clk);
      model_reset();

      // Free run from reset with a zero-wait memory
      hs_log.delete();
      step(1, 0, 0, 1, 1, 1);
      chk("first_cycle_req", inst_req, 1'b0);
      repeat (11) step(1, 0, 0, 1, 1, 1);
      for (int i = 0; i < 4; i++)
         chk("freerun_addr", (i < hs_log.size()) ? hs_log[i] : 32'hFFFF_FFFF, 32'(i * 4));

      // Stall with 0x8 held
      step(0, 0, 0, 1, 0, 1);
      repeat (7) step(1, 0, 0, 1, 1, 1);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0, 1, 1);
         chk("stall_valid", if_valid, 1'b1);
         chk("stall_pc", if_pc, 32'h8);
         chk("stall_req", inst_req, 1'b0);
      end
      step(1, 0, 0, 1, 1, 1);
      chk("resume_req", inst_req, 1'b1);
      chk("resume_addr", inst_addr, 32'hC);
      step(1, 0, 0, 1, 0, 1);

      // Redirect while waiting for data
      force_en = 1; force_val = 32'h0000_DEAD;
      step(1, 0, 0, 1, 1, 4);
      chk("wait_addr", inst_addr, 32'h10);
      step(1, 1, 32'h100, 1, 0, 1);
      chk("no_dead", (if_valid && if_inst == 32'hDEAD), 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 1, 0, 1);
         chk("no_dead", (if_valid && if_inst == 32'hDEAD), 1'b0);
      end
      force_en = 0;
      step(1, 0, 0, 1, 1, 1);
      chk("redir_req", inst_req, 1'b1);
      chk("redir_addr", inst_addr, 32'h100);
      chk("no_dead", (if_valid && if_inst == 32'hDEAD), 1'b0);

      // Redirect with data_ok, then redirect with addr_ok
      step(1, 1, 32'h200, 1, 0, 1);
      step(1, 1, 32'h103, 1, 1, 2);
      chk("dok_redir_addr", inst_addr, 32'h200);
      chk("dok_redir_valid", if_valid, 1'b0);
      step(1, 0, 0, 1, 0, 1);
      chk("cancel_req", inst_req, 1'b0);
      chk("cancel_valid", if_valid, 1'b0);
      step(1, 0, 0, 1, 0, 1);
      step(1, 0, 0, 1, 1, 2);
      chk("aok_redir_addr", inst_addr, 32'h100);
      chk("aok_redir_req", inst_req, 1'b1);

      // Reset while waiting; stale data_ok arrives in IDLE
      step(0, 0, 0, 1, 0, 1);
      step(1, 0, 0, 1, 0, 1);
      chk("rst_req", inst_req, 1'b0);
      chk("rst_valid", if_valid, 1'b0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_inst", if_inst, 32'h0);
      step(1, 0, 0, 1, 0, 1);
      chk("rst_fetch_req", inst_req, 1'b1);
      chk("rst_fetch_addr", inst_addr, 32'h0);
      step(1, 0, 0, 1, 0, 1);
      chk("stale_ignored", if_valid, 1'b0);

      // PC wrap
      step(1, 1, 32'hFFFF_FFFC, 1, 0, 1);
      step(1, 0, 0, 1, 1, 1);
      chk("wrap_top_addr", inst_addr, 32'hFFFF_FFFC);
      step(1, 0, 0, 1, 0, 1);
      step(1, 0, 0, 1, 0, 1);
      chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap_addr", inst_addr, 32'h0);
      chk("wrap_req", inst_req, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(1, ($urandom_range(0, 15) == 0), $urandom,
              ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
              int'($urandom_range(1, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Sequences instruction fetch for the 5-stage pipeline.
- Owns the fetch PC and drives a split-transaction instruction-memory port (req/addr_ok/data_ok).
- Holds one fetched instruction in an IF output register for ID, and applies branch/jump redirects from EX/ID, cancelling any in-flight fetch.
- At most one outstanding memory request.

Parameters:
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset.
- PC_W, 32: PC and instruction width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  PC_W  redirect target; bits [1:0] are forced to 0 internally.
- id_allowin  in  1  ID accepts the IF output this cycle.
- inst_req  out  1  fetch request valid.
- inst_addr  out  PC_W  fetch address (word aligned).
- inst_addr_ok  in  1  memory accepted the request this cycle.
- inst_data_ok  in  1  read data returned this cycle.
- inst_rdata  in  PC_W  returned instruction.
- if_valid  out  1  IF output register holds a valid instruction.
- if_pc  out  PC_W  PC of the held instruction.
- if_inst  out  PC_W  held instruction.

Behaviour:
- Reset (resetn=0 at a clock edge, any state, mid-transaction included):
  - state<=IDLE, fetch_pc<=RESET_PC.
  - if_valid/if_pc/if_inst<=0; inst_req=0.
  - Any data_ok belonging to a pre-reset request is ignored: IDLE discards data_ok.
- State machine:
  - IDLE: inst_req=0; next state REQ unconditionally.
  - REQ: inst_req=1 iff (!if_valid || id_allowin); inst_addr=fetch_pc.
    - Handshake occurs when inst_req && inst_addr_ok.
    - On handshake: req_pc<=fetch_pc; go WAIT, or CANCEL if redirect_valid in the same cycle.
    - No handshake: stay in REQ. Address may change while unaccepted, e.g. on redirect.
  - WAIT: inst_req=0.
    - On inst_data_ok with redirect_valid=0: if_valid<=1, if_pc<=req_pc, if_inst<=inst_rdata, fetch_pc<=req_pc+4; go REQ.
    - On redirect_valid (with or without data_ok): data is discarded.
      - If data_ok is in the same cycle: go REQ.
      - Otherwise: go CANCEL.
  - CANCEL: inst_req=0; on inst_data_ok discard data, go REQ.
- Redirect handling, any non-IDLE state:
  - fetch_pc<=redirect_pc&~3 and if_valid<=0.
  - Redirect has priority over id_allowin, data_ok and the PC increment.
  - A redirect in CANCEL only updates fetch_pc; state stays CANCEL.
- Output register:
  - if_valid clears when id_allowin=1 and no new data is written that cycle.
  - Write and consume in the same cycle: the new entry replaces the old.
  - With id_allowin=0, if_* hold stable.
- Fullness: a request is issued only when the output register is free or being consumed. With one outstanding request, the register is guaranteed empty at data_ok, so no skid storage is needed.
- Latency and throughput:
  - Request to if_valid is one cycle after data_ok (registered output).
  - Peak throughput is one instruction per 2 cycles with a zero-wait memory.
- Arithmetic: PC+4 wraps modulo 2^PC_W (32'hFFFF_FFFC -> 32'h0).
- Spurious data_ok in REQ or IDLE is ignored; assertion-flagged in verification.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, REQ, WAIT, CANCEL}, 2 bits;
  - RESET_PC default constant;
  - PC_INC=4.
- Single module; no sub-module. The output register is a few lines and stays inline.

Test Plan:
- Reset then free-run:
  - Stimulus: addr_ok=1 always, data_ok one cycle after accept, rdata=addr^32'hA5A5_0000, id_allowin=1.
  - Response: inst_addr 0,4,8,...; if_pc/if_inst match; inst_req=0 during the first cycle after reset.
- Stall:
  - Stimulus: id_allowin=0 for 5 cycles with if_valid=1 at if_pc=0x8.
  - Response: if_* stable; no request issued; fetch resumes at 0xC the cycle id_allowin=1.
- Redirect in WAIT:
  - Stimulus: request for 0x10 accepted, then redirect_pc=0x100 before data_ok; data_ok arrives 3 cycles later with rdata=0xDEAD.
  - Response: 0xDEAD never appears on if_inst; next inst_addr=0x100.
- Redirect coincident with data_ok, and coincident with addr_ok:
  - Response: data discarded; for the addr_ok case state goes to CANCEL and the following request is for redirect_pc; redirect_pc=0x103 fetches 0x100.
- Reset mid-transaction:
  - Stimulus: resetn=0 for 1 cycle while in WAIT; stale data_ok returned the next cycle.
  - Response: if_valid=0; stale data ignored; next request at RESET_PC.
- Wrap:
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Response: following fetch address is 0x0000_0000.
